// File: rtl/rc5_stream_ctrl.sv
// Sequencer in front of an rc5 core: runs the key schedule, then streams one 32-bit block at a
// time through the core with ECB or CBC chaining, guarded by a watchdog on every core wait.
module rc5_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [4:0]   cfg_rounds,
  input  logic         cfg_cbc,
  input  logic         cfg_decrypt,
  input  logic [31:0]  cfg_iv,
  output logic         cfg_busy,
  output logic         err_timeout,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic [127:0] core_key,
  output logic [4:0]   core_num_rounds,
  output logic         core_load_key,
  input  logic         core_key_ready,
  output logic         core_start_encrypt,
  output logic         core_start_decrypt,
  output logic [31:0]  core_d_in,
  input  logic [31:0]  core_d_out,
  input  logic         core_done
);

  typedef enum logic [2:0] {
    StIdle, StKeyLoad, StKeyWait, StReady, StIssue, StWait, StOut
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       key_q;
  logic [4:0]         rounds_q;
  logic               cbc_q, decrypt_q;
  logic [31:0]        chain_q, hold_q, din_q, mdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q;

  logic               load_acc, blk_acc, key_ok, wd_expire, wd_abort;
  logic [CNT_W:0]     cnt_inc;
  logic [31:0]        result;

  assign load_acc  = cfg_load && ((state_q == StIdle) || (state_q == StReady));
  assign blk_acc   = (state_q == StReady) && s_valid && !cfg_load;
  // A zero count marks the first KEYWAIT cycle, where a stale key_ready must be ignored.
  assign key_ok    = (cnt_q != '0) && core_key_ready;
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign wd_expire = cnt_inc >= (CNT_W + 1)'(TIMEOUT_CYCLES);
  assign wd_abort  = wd_expire && (((state_q == StKeyWait) && !key_ok) ||
                                   ((state_q == StWait) && !core_done));
  assign result    = (cbc_q && decrypt_q) ? (core_d_out ^ chain_q) : core_d_out;

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      rounds_q  <= '0;
      cbc_q     <= 1'b0;
      decrypt_q <= 1'b0;
      chain_q   <= '0;
      hold_q    <= '0;
      din_q     <= '0;
      mdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_acc) begin
        key_q     <= cfg_key;
        rounds_q  <= cfg_rounds;
        cbc_q     <= cfg_cbc;
        decrypt_q <= cfg_decrypt;
        chain_q   <= cfg_iv;
      end
      if (load_acc) begin
        err_q <= 1'b0;
      end else if (wd_abort) begin
        err_q <= 1'b1;
      end
      if (blk_acc) begin
        din_q  <= (cbc_q && !decrypt_q) ? (s_data ^ chain_q) : s_data;
        hold_q <= s_data;
      end
      if ((state_q == StWait) && core_done) begin
        mdata_q <= result;
        if (cbc_q) begin
          chain_q <= decrypt_q ? hold_q : core_d_out;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cfg_load) state_d = StKeyLoad;
      StKeyLoad: state_d = StKeyWait;
      StKeyWait: begin
        if (key_ok)        state_d = StReady;
        else if (wd_abort) state_d = StIdle;
      end
      StReady: begin
        if (cfg_load)     state_d = StKeyLoad;
        else if (s_valid) state_d = StIssue;
      end
      StIssue:   state_d = StWait;
      StWait: begin
        if (core_done)     state_d = StOut;
        else if (wd_abort) state_d = StIdle;
      end
      StOut:     if (m_ready) state_d = StReady;
      default:   state_d = StIdle;
    endcase
  end

  // Watchdog counter: cleared in the cycle before each wait, saturating during it
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == StKeyLoad) || (state_q == StIssue)) begin
      cnt_d = '0;
    end else if (((state_q == StKeyWait) || (state_q == StWait)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    cfg_busy           = 1'b0;
    s_ready            = 1'b0;
    m_valid            = 1'b0;
    core_load_key      = 1'b0;
    core_start_encrypt = 1'b0;
    core_start_decrypt = 1'b0;
    unique case (state_q)
      StIdle:    ;
      StKeyLoad: begin
        cfg_busy      = 1'b1;
        core_load_key = 1'b1;
      end
      StKeyWait: cfg_busy = 1'b1;
      StReady:   s_ready = !cfg_load;
      StIssue: begin
        cfg_busy           = 1'b1;
        core_start_encrypt = !decrypt_q;
        core_start_decrypt = decrypt_q;
      end
      StWait:    cfg_busy = 1'b1;
      StOut: begin
        cfg_busy = 1'b1;
        m_valid  = 1'b1;
      end
      default:   ;
    endcase
  end

  assign err_timeout     = err_q;
  assign m_data          = mdata_q;
  assign core_key        = key_q;
  assign core_num_rounds = rounds_q;
  assign core_d_in       = din_q;

endmodule

// File: tb/tb_rc5_stream_ctrl.sv
// Directed bench for rc5_stream_ctrl with a behavioural core stub (d_out = d_in ^ A5A5A5A5).
module tb_rc5_stream_ctrl;

  localparam logic [127:0] Key = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         cfg_load = 1'b0, cfg_load2 = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [4:0]   cfg_rounds = '0;
  logic         cfg_cbc = 1'b0, cfg_decrypt = 1'b0;
  logic [31:0]  cfg_iv = '0;
  logic         s_valid = 1'b0, s_valid2 = 1'b0;
  logic [31:0]  s_data = '0;
  logic         m_ready = 1'b0;
  logic         kr2 = 1'b0;

  logic         cfg_busy, err_timeout, s_ready, m_valid;
  logic [31:0]  m_data, core_d_in, core_d_out;
  logic [127:0] core_key;
  logic [4:0]   core_num_rounds;
  logic         core_load_key, core_key_ready, core_start_encrypt, core_start_decrypt, core_done;

  logic         cfg_busy2, err2, s_ready2, m_valid2, load_key2, start_enc2, start_dec2;
  logic [31:0]  m_data2, d_in2;
  logic [127:0] core_key2;
  logic [4:0]   rounds2;

  rc5_stream_ctrl dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_rounds(cfg_rounds),
    .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt), .cfg_iv(cfg_iv), .cfg_busy(cfg_busy),
    .err_timeout(err_timeout), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .core_key(core_key),
    .core_num_rounds(core_num_rounds), .core_load_key(core_load_key),
    .core_key_ready(core_key_ready), .core_start_encrypt(core_start_encrypt),
    .core_start_decrypt(core_start_decrypt), .core_d_in(core_d_in), .core_d_out(core_d_out),
    .core_done(core_done)
  );

  // Short watchdog instance whose core never completes a block.
  rc5_stream_ctrl #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load2), .cfg_key(cfg_key), .cfg_rounds(cfg_rounds),
    .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt), .cfg_iv(cfg_iv), .cfg_busy(cfg_busy2),
    .err_timeout(err2), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .core_key(core_key2),
    .core_num_rounds(rounds2), .core_load_key(load_key2), .core_key_ready(kr2),
    .core_start_encrypt(start_enc2), .core_start_decrypt(start_dec2), .core_d_in(d_in2),
    .core_d_out(32'h0), .core_done(1'b0)
  );

  // Core stub: key_ready 20 cycles after load_key, done 6 cycles after start.
  logic [4:0] kcnt = '0;
  logic [5:0] sr = '0;
  int nload = 0, nstart = 0, ndone = 0;
  always @(posedge clk) begin
    if (core_load_key) kcnt <= 5'd1;
    else if (kcnt != 5'd0 && kcnt != 5'd20) kcnt <= kcnt + 5'd1;
    sr <= {sr[4:0], core_start_encrypt | core_start_decrypt};
    if (core_load_key) nload <= nload + 1;
    if (core_start_encrypt | core_start_decrypt) nstart <= nstart + 1;
    if (core_done) ndone <= ndone + 1;
  end
  assign core_key_ready = (kcnt == 5'd20);
  assign core_done      = sr[5];
  assign core_d_out     = core_d_in ^ 32'hA5A5_A5A5;

  int total = 0, bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic cbc, input logic dec, input logic [31:0] iv,
                        output int n);
    cfg_key = Key; cfg_rounds = 5'd12; cfg_cbc = cbc; cfg_decrypt = dec; cfg_iv = iv;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    n = 1;
    while (!s_ready && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] d, input logic [31:0] din_exp,
                      input logic [31:0] exp, input logic dec);
    int n;
    s_valid = 1'b1; s_data = d;
    tick;
    s_valid = 1'b0;
    chk({tag, " start"}, {126'd0, core_start_encrypt, core_start_decrypt}, {126'd0, ~dec, dec});
    chk({tag, " d_in"}, core_d_in, din_exp);
    n = 1;
    while (!m_valid && n < 200) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, n, 8);
    chk({tag, " data"}, m_data, exp);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk({tag, " m_valid drop"}, m_valid, 0);
    chk({tag, " s_ready back"}, s_ready, 1);
  endtask

  initial begin
    int n, ns, nl, nd;
    logic ok, mv;

    // Reset state
    tick; tick;
    chk("rst outs", {cfg_busy, err_timeout, s_ready, m_valid, core_load_key,
                     core_start_encrypt, core_start_decrypt}, 0);
    chk("rst m_data", m_data, 0);
    chk("rst core_key", core_key, 0);
    chk("rst d_in", core_d_in, 0);
    chk("rst dut2 outs", {cfg_busy2, err2, s_ready2, m_valid2, load_key2}, 0);
    rst = 1'b1;
    tick;

    // 1: ECB encrypt
    cfg_key = Key; cfg_rounds = 5'd12; cfg_cbc = 1'b0; cfg_decrypt = 1'b0;
    cfg_load = 1'b1;
    tick;
    cfg_load = 1'b0;
    chk("keyload pulse", core_load_key, 1);
    chk("keyload busy", cfg_busy, 1);
    chk("core_key", core_key, Key);
    chk("core_rounds", core_num_rounds, 12);
    n = 1;
    while (!s_ready && n < 200) begin
      tick;
      n++;
    end
    chk("ecb s_ready delay", n, 22);
    chk("ecb key_ready", core_key_ready, 1);
    chk("ecb load once", nload, 1);
    xfer("ecb", 32'h1234_5678, 32'h1234_5678, 32'hB791_F3DD, 1'b0);

    // 2: CBC encrypt
    do_cfg(1'b1, 1'b0, 32'hFFFF_0000, n);
    chk("cbce s_ready delay", n, 22);
    xfer("cbce b1", 32'h0000_0001, 32'hFFFF_0001, 32'h5A5A_A5A4, 1'b0);
    xfer("cbce b2", 32'h0000_0002, 32'h5A5A_A5A6, 32'hFFFF_0003, 1'b0);

    // 3: CBC decrypt of the scenario-2 ciphertext
    do_cfg(1'b1, 1'b1, 32'hFFFF_0000, n);
    chk("cbcd s_ready delay", n, 22);
    xfer("cbcd b1", 32'h5A5A_A5A4, 32'h5A5A_A5A4, 32'h0000_0001, 1'b1);
    xfer("cbcd b2", 32'hFFFF_0003, 32'hFFFF_0003, 32'h0000_0002, 1'b1);

    // 4: backpressure with an ignored cfg_load; chain is now FFFF0003
    s_valid = 1'b1; s_data = 32'hA5A5_A5A5;
    tick;
    s_valid = 1'b0;
    n = 1;
    while (!m_valid && n < 200) begin
      tick;
      n++;
    end
    chk("hold data", m_data, 32'hFFFF_0003);
    ns = nstart; nl = nload; ok = 1'b1;
    cfg_key = 128'hDEAD_BEEF; cfg_load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!(m_valid === 1'b1 && m_data === 32'hFFFF_0003 && s_ready === 1'b0 &&
            cfg_busy === 1'b1)) ok = 1'b0;
    end
    cfg_load = 1'b0;
    chk("hold stable", ok, 1);
    chk("hold no start", nstart - ns, 0);
    chk("hold no keyload", nload - nl, 0);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("hold release", m_valid, 0);
    chk("hold key kept", core_key, Key);

    // 5: watchdog on dut2, with a stale key_ready already high
    kr2 = 1'b1;
    cfg_load2 = 1'b1;
    tick;
    cfg_load2 = 1'b0;
    tick;
    tick;
    chk("stale key ignored", s_ready2, 0);
    tick;
    chk("dut2 ready", s_ready2, 1);
    s_valid2 = 1'b1;
    tick;
    s_valid2 = 1'b0;
    tick;
    for (int i = 0; i < 14; i++) tick;
    chk("wd before expiry", {err2, cfg_busy2}, 2'b01);
    tick;
    chk("wd err set", err2, 1);
    chk("wd idle", {s_ready2, cfg_busy2, m_valid2}, 0);
    cfg_load2 = 1'b1;
    tick;
    cfg_load2 = 1'b0;
    chk("wd err cleared", err2, 0);

    // 6: reset during WAIT
    s_valid = 1'b1; s_data = 32'h1111_2222;
    tick;
    s_valid = 1'b0;
    tick;
    tick;
    chk("in wait", cfg_busy, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("midrst outs", {cfg_busy, err_timeout, s_ready, m_valid, core_load_key,
                        core_start_encrypt, core_start_decrypt}, 0);
    chk("midrst m_data", m_data, 0);
    chk("midrst d_in", core_d_in, 0);
    chk("midrst core_key", core_key, 0);
    nd = ndone; mv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (m_valid !== 1'b0) mv = 1'b1;
    end
    chk("midrst done seen", ndone - nd, 1);
    chk("midrst no output", mv, 0);
    chk("midrst idle", s_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
